// File: rtl/axis_uart_rx.sv
// ============================================================================
// Module   : axis_uart_rx
// Purpose  : UART receiver. Emits each byte as an AXI-Stream beat carrying
//            {frame_err, parity_err}. Define AXIS_UART_RX_FIFO_EN to add the
//            FIFO_DEPTH-entry output FIFO; otherwise one holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_uart_rx #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [7:0]  maxis_data_o,
    output logic [1:0]  maxis_tuser_o,
    output logic        maxis_tvalid_o,
    input  logic        maxis_tready_i,
    output logic        overrun_o,
    input  logic [31:0] delitel,
    input  logic        stop_bit_num,
    input  logic [2:0]  parity_bit_mode
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP1   = 3'd4,
        S_STOP2   = 3'd5,
        S_DELIVER = 3'd6
    } state_t;

    state_t      state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [31:0] div_q, cnt_q;
    logic        two_stop_q;
    logic [2:0]  mode_q;
    logic [7:0]  shift_q;
    logic [2:0]  bit_idx_q;
    logic        par_err_q, frm_err_q;

    logic        w_fall, w_tick, w_par_exp, w_push, w_pop;
    logic [31:0] w_div;
    logic [9:0]  w_word;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign w_fall = rx_prev_q & ~rx_sync_q;
    assign w_div  = (delitel < 32'd2) ? 32'd2 : delitel;
    assign w_tick = (cnt_q == div_q - 32'd1);
    assign w_push = (state_q == S_DELIVER);
    assign w_word = {frm_err_q, par_err_q, shift_q};

    always_comb begin
        w_par_exp = 1'b0;
        case (mode_q)
            3'd1:    w_par_exp = 1'b1;
            3'd2:    w_par_exp = ~^shift_q;
            3'd3:    w_par_exp = ^shift_q;
            default: w_par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            div_q      <= 32'd2;
            cnt_q      <= 32'd0;
            two_stop_q <= 1'b0;
            mode_q     <= 3'd0;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_fall) begin
                        // Start half a bit early so every sample lands mid-bit.
                        div_q      <= w_div;
                        cnt_q      <= w_div - (w_div >> 1);
                        two_stop_q <= stop_bit_num;
                        mode_q     <= parity_bit_mode;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        bit_idx_q  <= 3'd0;
                        state_q    <= S_START;
                    end
                end
                S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
                    if (!w_tick) begin
                        cnt_q <= cnt_q + 32'd1;
                    end else begin
                        cnt_q <= 32'd0;
                        case (state_q)
                            S_START:  state_q <= rx_sync_q ? S_IDLE : S_DATA;
                            S_DATA: begin
                                shift_q   <= {rx_sync_q, shift_q[7:1]};
                                bit_idx_q <= bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7)
                                    state_q <= S_PARITY;
                            end
                            S_PARITY: begin
                                par_err_q <= (rx_sync_q != w_par_exp);
                                state_q   <= S_STOP1;
                            end
                            S_STOP1: begin
                                if (!rx_sync_q)
                                    frm_err_q <= 1'b1;
                                state_q <= two_stop_q ? S_STOP2 : S_DELIVER;
                            end
                            default: begin
                                if (!rx_sync_q)
                                    frm_err_q <= 1'b1;
                                state_q <= S_DELIVER;
                            end
                        endcase
                    end
                end
                S_DELIVER: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

`ifdef AXIS_UART_RX_FIFO_EN
    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [9:0]         mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q, w_rd_next;
    logic [c_cnt_w-1:0] count_q, w_remain;
    logic [9:0]         head_q;
    logic               overrun_q, w_full, w_accept;

    assign w_full    = (count_q == c_cnt_w'(FIFO_DEPTH));
    assign w_pop     = (count_q != '0) & maxis_tready_i;
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_rd_next = rd_ptr_q + c_ptr_w'(w_pop);
    assign w_remain  = count_q - c_cnt_w'(w_pop);

    always_ff @(posedge clk) begin
        if (w_accept)
            mem_q[wr_ptr_q] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= 10'd0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + c_ptr_w'(w_accept);
            rd_ptr_q  <= w_rd_next;
            count_q   <= w_remain + c_cnt_w'(w_accept);
            overrun_q <= w_push & w_full & ~w_pop;
            // Head register tracks the entry that will be at rd_ptr next cycle.
            if (w_remain == '0) begin
                if (w_accept)
                    head_q <= w_word;
            end else begin
                head_q <= mem_q[w_rd_next];
            end
        end
    end

    assign maxis_tvalid_o = (count_q != '0);
    assign maxis_data_o   = head_q[7:0];
    assign maxis_tuser_o  = head_q[9:8];
    assign overrun_o      = overrun_q;
`else
    logic [9:0] hold_q;
    logic       tvalid_q, overrun_q;
    logic       w_unused_depth;

    assign w_unused_depth = ^FIFO_DEPTH;
    assign w_pop          = tvalid_q & maxis_tready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q    <= 10'd0;
            tvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= w_push & tvalid_q & ~maxis_tready_i;
            if (w_push && (!tvalid_q || maxis_tready_i)) begin
                hold_q   <= w_word;
                tvalid_q <= 1'b1;
            end else if (w_pop) begin
                tvalid_q <= 1'b0;
            end
        end
    end

    assign maxis_tvalid_o = tvalid_q;
    assign maxis_data_o   = hold_q[7:0];
    assign maxis_tuser_o  = hold_q[9:8];
    assign overrun_o      = overrun_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_uart_rx.sv
// ============================================================================
// Module   : tb_axis_uart_rx
// Purpose  : Directed self-checking bench for axis_uart_rx (delitel = 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic        tready = 1'b0;
    logic [31:0] delitel = 32'd16;
    logic        stop_num = 1'b0;
    logic [2:0]  mode = 3'd3;
    logic [7:0]  data_o;
    logic [1:0]  tuser_o;
    logic        tvalid_o;
    logic        overrun_o;

    axis_uart_rx #(.FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_rx         (uart_rx),
        .maxis_data_o    (data_o),
        .maxis_tuser_o   (tuser_o),
        .maxis_tvalid_o  (tvalid_o),
        .maxis_tready_i  (tready),
        .overrun_o       (overrun_o),
        .delitel         (delitel),
        .stop_bit_num    (stop_num),
        .parity_bit_mode (mode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rise_cyc = 0;
    int rise_cnt = 0;
    int ovr_cnt  = 0;
    int start_cyc = 0;
    logic tv_prev = 1'b0;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (tvalid_o && !tv_prev) begin
            rise_cyc = cyc;
            rise_cnt++;
        end
        tv_prev = tvalid_o;
        if (overrun_o)
            ovr_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Live config is scrambled mid-frame to prove it is latched at the start edge.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1,
                              input logic s2, input logic two);
        logic        bits [12];
        logic [2:0]  sv_mode;
        logic        sv_stop;
        int          nb;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = pbit;
        bits[10] = s1;
        bits[11] = s2;
        nb = two ? 12 : 11;
        sv_mode = mode;
        sv_stop = stop_num;
        @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            uart_rx = bits[i];
            if (i == 0) start_cyc = cyc;
            if (i == 2) begin
                mode     = ~sv_mode;
                stop_num = ~sv_stop;
                delitel  = 32'd5;
            end
            repeat (16) @(negedge clk);
        end
        uart_rx  = 1'b1;
        mode     = sv_mode;
        stop_num = sv_stop;
        delitel  = 32'd16;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 600 && !tvalid_o; k++) @(negedge clk);
        check(name, {31'd0, tvalid_o}, 32'd1);
    endtask

    task automatic pop_one(input string name);
        tready = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        check(name, {31'd0, tvalid_o}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s1;
        logic       s2;
        logic       two;
        logic [2:0] md;
        logic [7:0] ed;
        logic [1:0] eu;
    } vec_t;

    vec_t vecs [9];
    logic [7:0] exp_q [3];
    int n_exp, n_ovr, got, r0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'hA5, 2'b00};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h01, 2'b00};
        vecs[2] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 8'h01, 2'b01};
        vecs[3] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h5A, 2'b00};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h80, 2'b01};
        vecs[5] = '{8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 8'h7E, 2'b00};
        vecs[6] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 8'hF0, 2'b10};
        vecs[7] = '{8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 8'h0F, 2'b11};
        vecs[8] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 8'h3C, 2'b00};

        repeat (3) @(negedge clk);
        check("reset_tvalid", {31'd0, tvalid_o}, 32'd0);
        check("reset_data", {24'd0, data_o}, 32'd0);
        check("reset_tuser", {30'd0, tuser_o}, 32'd0);
        check("reset_overrun", {31'd0, overrun_o}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Frame format, parity modes, stop errors and exact latency.
        for (int v = 0; v < 9; v++) begin
            mode     = vecs[v].md;
            stop_num = vecs[v].two;
            send_frame(vecs[v].d, vecs[v].p, vecs[v].s1, vecs[v].s2, vecs[v].two);
            wait_valid($sformatf("v%0d_valid", v));
            check($sformatf("v%0d_latency", v), rise_cyc - start_cyc, vecs[v].two ? 188 : 172);
            check($sformatf("v%0d_data", v), {24'd0, data_o}, {24'd0, vecs[v].ed});
            check($sformatf("v%0d_tuser", v), {30'd0, tuser_o}, {30'd0, vecs[v].eu});
            pop_one($sformatf("v%0d_pop", v));
        end
        check("no_overrun_table", ovr_cnt, 0);

        // Break: one 0x00 byte with frame error, then silence until line high.
        mode = 3'd3; stop_num = 1'b0;
        r0 = rise_cnt;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (320) @(negedge clk);
        check("break_bytes", rise_cnt - r0, 1);
        check("break_data", {24'd0, data_o}, 32'd0);
        check("break_tuser", {30'd0, tuser_o}, 32'd2);
        pop_one("break_pop");
        repeat (64) @(negedge clk);
        check("break_rearm", rise_cnt - r0, 1);
        uart_rx = 1'b1;
        repeat (48) @(negedge clk);

        // False start: 5-cycle glitch, then a good frame.
        r0 = rise_cnt;
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (48) @(negedge clk);
        check("glitch_no_output", rise_cnt - r0, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid("glitch_valid");
        check("glitch_data", {24'd0, data_o}, 32'h3C);
        check("glitch_tuser", {30'd0, tuser_o}, 32'd0);
        pop_one("glitch_pop");

        // Back-pressure and overrun.
        ovr_cnt = 0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
`ifdef AXIS_UART_RX_FIFO_EN
        n_exp = 2; n_ovr = 1;
`else
        n_exp = 1; n_ovr = 2;
`endif
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33;
        check("ovr_count", ovr_cnt, n_ovr);
        check("ovr_head", {24'd0, data_o}, 32'h11);
        got = 0;
        tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (tvalid_o) begin
                if (got < 3)
                    check($sformatf("drain%0d", got), {24'd0, data_o}, {24'd0, exp_q[got]});
                got++;
            end
            @(negedge clk);
        end
        tready = 1'b0;
        check("drain_count", got, n_exp);

        // Reset mid-frame with a byte already held.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid("pre_reset_valid");
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = (i < 2);
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_tvalid", {31'd0, tvalid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_tuser", {30'd0, tuser_o}, 32'd0);
        check("rst_overrun", {31'd0, overrun_o}, 32'd0);
        r0 = rise_cnt;
        repeat (200) @(negedge clk);
        check("rst_discard", rise_cnt - r0, 0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_valid("post_rst_valid");
        check("post_rst_data", {24'd0, data_o}, 32'hC3);
        check("post_rst_tuser", {30'd0, tuser_o}, 32'd0);
        pop_one("post_rst_pop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
